// File: rtl/phase_dmp_pkg.sv
// Shared constants and types for the phase dump sequencer:
// control-word bit positions, FSM states and default widths.
package phase_dmp_pkg;

  localparam int ARM_BIT   = 31;
  localparam int ABORT_BIT = 30;
  localparam int DECIM_LSB = 16;
  localparam int DECIM_W   = 4;

  localparam int CH_W_DEF   = 8;
  localparam int PHS_W_DEF  = 16;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/phase_dmp_edge.sv
// Single-bit rising-edge detector (used for the arm bit).
// Ports: clk, rst (sync, active-high), d level in, rise = d & ~d_q.
module phase_dmp_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/phase_dmp_ctrl.sv
// Phase dump sequencer: arms from the control word, waits for SOF,
// then writes one channel's phase samples into the dump buffer.
// Ports: user_clk/user_rst, user_data_out control word, phs_* stream
// in, dmp_we/dmp_addr/dmp_data buffer write port, busy/done/dmp_count.
// Optional decimation of matches: define PHASE_DMP_DECIM_EN.
module phase_dmp_ctrl
  import phase_dmp_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int PHS_W  = PHS_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       user_data_out,
  input  logic              phs_valid,
  input  logic              phs_sof,
  input  logic [CH_W-1:0]   phs_ch,
  input  logic [PHS_W-1:0]  phs_data,
  output logic              dmp_we,
  output logic [ADDR_W-1:0] dmp_addr,
  output logic [PHS_W-1:0]  dmp_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   dmp_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t state, state_nx;

  logic              arm_evt;
  logic              abort;
  logic [CH_W-1:0]   ch_lat;
  logic [ADDR_W-1:0] wptr;
  logic              in_cap;
  logic              match;
  logic              keep;
  logic              wr_go;
  logic              last;
  logic              start;

  phase_dmp_edge u_arm (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (user_data_out[ARM_BIT]),
    .rise (arm_evt)
  );

  assign abort = user_data_out[ABORT_BIT];

  // The SOF sample itself is already eligible for capture.
  assign in_cap = (state == CAPTURE) ||
                  (state == WAIT_SOF && phs_valid && phs_sof);
  assign match  = phs_valid && (phs_ch == ch_lat);
  assign wr_go  = !abort && in_cap && match && keep;
  assign last   = wr_go && (wptr == '1);
  assign start  = !abort && arm_evt &&
                  (state == IDLE || state == DONE);

`ifdef PHASE_DMP_DECIM_EN
  logic [DECIM_W-1:0] decim_lat;
  logic [DECIM_W-1:0] dcnt;
  logic [DECIM_W-1:0] dmask;

  // Ratios beyond the counter range saturate at one in 16.
  assign dmask = (decim_lat >= DECIM_W'(4)) ? '1 :
                 (DECIM_W'(1) << decim_lat) - DECIM_W'(1);
  assign keep  = ((dcnt & dmask) == '0);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      decim_lat <= '0;
      dcnt      <= '0;
    end else if (start) begin
      decim_lat <= user_data_out[DECIM_LSB +: DECIM_W];
      dcnt      <= '0;
    end else if (!abort && in_cap && match) begin
      dcnt <= dcnt + DECIM_W'(1);
    end
  end

  logic unused_ctl;
  assign unused_ctl = ^{user_data_out[29:DECIM_LSB+DECIM_W],
                        user_data_out[DECIM_LSB-1:CH_W]};
`else
  assign keep = 1'b1;

  logic unused_ctl;
  assign unused_ctl = ^{user_data_out[29:DECIM_LSB],
                        user_data_out[DECIM_LSB-1:CH_W]};
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = WAIT_SOF;
      WAIT_SOF: begin
        if (abort)                  state_nx = IDLE;
        else if (last)              state_nx = DONE;
        else if (phs_valid && phs_sof) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        if (abort)      state_nx = IDLE;
        else if (start) state_nx = WAIT_SOF;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state     <= IDLE;
      ch_lat    <= '0;
      wptr      <= '0;
      dmp_we    <= 1'b0;
      dmp_addr  <= '0;
      dmp_data  <= '0;
      dmp_count <= '0;
    end else begin
      state  <= state_nx;
      dmp_we <= wr_go;
      if (start) begin
        ch_lat    <= user_data_out[CH_W-1:0];
        wptr      <= '0;
        dmp_addr  <= '0;
        dmp_count <= '0;
      end else if (wr_go) begin
        dmp_addr  <= wptr;
        dmp_data  <= phs_data;
        wptr      <= wptr + ADDR_ONE;
        dmp_count <= dmp_count + CNT_ONE;
      end
    end
  end

  assign busy = (state == WAIT_SOF) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_phase_dmp_ctrl.sv
// Randomized scoreboard bench for phase_dmp_ctrl.
// Expected writes are queued by a behavioural model; a monitor pops them.
module tb_phase_dmp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] user_data_out;
  logic        phs_valid;
  logic        phs_sof;
  logic [7:0]  phs_ch;
  logic [15:0] phs_data;
  logic        dmp_we;
  logic [9:0]  dmp_addr;
  logic [15:0] dmp_data;
  logic        busy;
  logic        done;
  logic [10:0] dmp_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  phase_dmp_ctrl dut (
    .user_clk      (clk),
    .user_rst      (rst),
    .user_data_out (user_data_out),
    .phs_valid     (phs_valid),
    .phs_sof       (phs_sof),
    .phs_ch        (phs_ch),
    .phs_data      (phs_data),
    .dmp_we        (dmp_we),
    .dmp_addr      (dmp_addr),
    .dmp_data      (dmp_data),
    .busy          (busy),
    .done          (done),
    .dmp_count     (dmp_count)
  );

  typedef struct {
    int cy;
    int addr;
    int data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: software-visible dump status.
  bit m_armq, m_wait, m_cap, m_done;
  int m_ch, m_n, m_match, m_dec;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [31:0] w, input logic v, input logic s,
                      input logic [7:0] c, input logic [15:0] d);
    bit arm_e;
    bit keep;
    @(negedge clk);
    user_data_out = w;
    phs_valid     = v;
    phs_sof       = s;
    phs_ch        = c;
    phs_data      = d;
    arm_e  = w[31] && !m_armq;
    m_armq = w[31];
    if (w[30]) begin
      m_wait = 0;
      m_cap  = 0;
      m_done = 0;
    end else if (arm_e && !m_wait && !m_cap) begin
      m_wait  = 1;
      m_done  = 0;
      m_ch    = int'(w[7:0]);
      m_n     = 0;
      m_match = 0;
      m_dec   = int'(w[19:16]);
    end else begin
      if (m_wait && v && s) begin
        m_wait = 0;
        m_cap  = 1;
      end
      if (m_cap && v && int'(c) == m_ch) begin
        keep = 1;
`ifdef PHASE_DMP_DECIM_EN
        keep = (m_match % (1 << (m_dec > 4 ? 4 : m_dec))) == 0;
        m_match++;
`endif
        if (keep) begin
          q.push_back('{cyc + 1, m_n % 1024, int'(d)});
          m_n++;
          if (m_n == 1024) begin
            m_cap  = 0;
            m_done = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("busy", busy, longint'(m_wait || m_cap));
    chk("done", done, longint'(m_done));
    chk("dmp_count", dmp_count, m_n);
  endtask

  task automatic noise(input logic [31:0] w);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1)
        step(w, 1'b0, 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 16'($urandom));
      else
        step(w, 1'b1, 1'b0, 8'($urandom_range(1, 255)), 16'($urandom));
    end
  endtask

  task automatic frame(input logic [31:0] w, input int tgt);
    step(w, 1'b1, 1'b1, 8'd0, 16'($urandom));
    noise(w);
    if (tgt != 0) step(w, 1'b1, 1'b0, 8'(tgt), 16'($urandom));
    noise(w);
  endtask

  task automatic run_dump(input logic [31:0] w, input int tgt, input int maxf);
    for (int f = 0; f < maxf && (m_wait || m_cap); f++) frame(w, tgt);
    chk("dump_finished", longint'(m_wait || m_cap), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dmp_we) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_write: addr=%0d data=%0h, none expected (cycle %0d)",
                   dmp_addr, dmp_data, cyc);
        end else begin
          e = q.pop_front();
          chk("wr_cycle", cyc, e.cy);
          chk("wr_addr", dmp_addr, e.addr);
          chk("wr_data", dmp_data, e.data);
        end
      end else if (q.size() > 0 && q[0].cy < cyc) begin
        e = q.pop_front();
        chk("missing_write", 0, 1);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    user_data_out = '0;
    phs_valid     = 1'b0;
    phs_sof       = 1'b0;
    phs_ch        = '0;
    phs_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", dmp_we, 0);
    chk("rst_addr", dmp_addr, 0);
    chk("rst_data", dmp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", dmp_count, 0);
    @(negedge clk);
    rst = 1'b0;
    fork
      monitor();
    join_none

    // Idle traffic: nothing may be written.
    repeat (5) frame(32'h0, 5);

    // Arm pulse on ch 5, SOF arrives 37 samples later.
    step(32'h8000_0005, 1'b0, 1'b0, 8'd0, 16'd0);
    for (int i = 0; i < 37; i++)
      step(32'h5, 1'(i % 2 == 0), 1'b0,
           (i % 4 == 0) ? 8'd5 : 8'($urandom_range(1, 255)), 16'($urandom));
    run_dump(32'h5, 5, 1200);
    chk("dumpA_full", dmp_count, 1024);

    // Arm held high through and after DONE must not re-arm.
    step(32'h8000_0009, 1'b0, 1'b0, 8'd0, 16'd0);
    run_dump(32'h8000_0009, 9, 1200);
    repeat (20) frame(32'h8000_0009, 9);
    chk("held_no_rearm", done, 1);
    step(32'h9, 1'b0, 1'b0, 8'd0, 16'd0);
    step(32'h8000_0009, 1'b1, 1'b0, 8'd9, 16'($urandom));
    chk("rearm_done_drop", done, 0);
    run_dump(32'h9, 9, 1200);

    // Abort partway through a dump.
    step(32'h8000_0020, 1'b0, 1'b0, 8'd0, 16'd0);
    for (int f = 0; f < 400 && m_n < 300; f++) frame(32'h20, 32);
    step(32'h4000_0000, 1'b1, 1'b0, 8'd32, 16'($urandom));
    chk("abort_busy", busy, 0);
    chk("abort_count_kept", dmp_count, m_n);
    repeat (10) frame(32'h0, 32);

    // Arm and abort together from IDLE: stays idle.
    step(32'hC000_0003, 1'b1, 1'b1, 8'd3, 16'd0);
    chk("arm_abort_idle", busy, 0);
    repeat (10) frame(32'h0, 3);

    // Channel 0: the SOF sample itself is captured.
    step(32'h8000_0000, 1'b0, 1'b0, 8'd0, 16'd0);
    run_dump(32'h0, 0, 1200);

`ifdef PHASE_DMP_DECIM_EN
    // One match in four, channel 200.
    step(32'h8002_00C8, 1'b0, 1'b0, 8'd0, 16'd0);
    run_dump(32'h0002_00C8, 200, 5000);
`endif

    repeat (5) step(32'h0, 1'b0, 1'b0, 8'd0, 16'd0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
